push_arbiter: RTL and testbench

Parametrised N-channel push arbiter: merges several single-word push producers (SPI receiver, MIL receivers, status generator) onto one push consumer such as the ring buffer write port. Each channel's one-cycle request pulse is latched so it is never lost. Channels are served round-robin, with optional per-channel lock for atomic multi-word packets. A per-transaction timeout recovers from a consumer that never returns done.

---
 rtl/push_arbiter_pkg.sv | 15 +
 rtl/push_arbiter_rr_picker.sv | 42 ++++
 rtl/push_arbiter.sv | 160 ++++++++++++++++
 tb/tb_push_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/push_arbiter_pkg.sv
// Shared types and helpers for the N-channel push arbiter.
package push_arbiter_pkg;

  localparam int DATAW_TOP = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } arb_state_e;

  function automatic int rr_next(input int idx, input int off, input int n);
    return (idx + off) % n;
  endfunction

endpackage

// File: rtl/push_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible pending channel at or after
// the pointer, optionally restricted to a single locked channel.
module rr_picker
  import push_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int IDXW     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] pending_i,
  input  logic [IDXW-1:0]     ptr_i,
  input  logic                lock_en_i,
  input  logic [IDXW-1:0]     lock_idx_i,
  output logic                valid_o,
  output logic [IDXW-1:0]     index_o
);

  logic [CHANNELS-1:0] elig_s;
  logic [IDXW-1:0]     cand_s;

  always_comb begin
    elig_s  = pending_i;
    cand_s  = ptr_i;
    valid_o = 1'b0;
    index_o = ptr_i;
    if (lock_en_i) begin
      elig_s             = '0;
      elig_s[lock_idx_i] = pending_i[lock_idx_i];
    end else begin
      elig_s = pending_i;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      cand_s = IDXW'(rr_next(int'(ptr_i), i, CHANNELS));
      if (!valid_o && elig_s[cand_s]) begin
        valid_o = 1'b1;
        index_o = cand_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/push_arbiter.sv
// Merges CHANNELS single-word push producers onto one push consumer with
// latched request slots, round-robin/lock arbitration and a done timeout.
module push_arbiter
  import push_arbiter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DATAW    = DATAW_TOP + 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic [CHANNELS-1:0]         in_request,
  input  logic [CHANNELS*DATAW-1:0]   in_data,
  input  logic [CHANNELS-1:0]         in_lock,
  output logic [CHANNELS-1:0]         in_done,
  output logic [CHANNELS-1:0]         in_err,
  output logic [CHANNELS-1:0]         in_ovf,
  output logic                        out_request,
  output logic [DATAW-1:0]            out_data,
  input  logic                        out_done,
  output logic [$clog2(CHANNELS)-1:0] grant,
  output logic                        busy
);

  localparam int IDXW = $clog2(CHANNELS);
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e          state_q, state_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [DATAW-1:0]    word_q [CHANNELS];
  logic [DATAW-1:0]    word_d [CHANNELS];
  logic [CHANNELS-1:0] done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic                oreq_q, oreq_d;
  logic [DATAW-1:0]    odata_q, odata_d;
  logic [IDXW-1:0]     grant_q, grant_d, rr_q, rr_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic [CHANNELS-1:0] release_s;
  logic                pick_valid_s, timeout_s;
  logic [IDXW-1:0]     pick_idx_s;

  rr_picker #(
    .CHANNELS (CHANNELS),
    .IDXW     (IDXW)
  ) u_picker (
    .pending_i  (pend_q),
    .ptr_i      (rr_q),
    .lock_en_i  (lock_q && in_lock[grant_q]),
    .lock_idx_i (grant_q),
    .valid_o    (pick_valid_s),
    .index_o    (pick_idx_s)
  );

  assign timeout_s = (TIMEOUT != 0) && (cnt_q == CNTW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    oreq_d    = 1'b0;
    odata_d   = odata_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    done_d    = '0;
    err_d     = '0;
    release_s = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          oreq_d  = 1'b1;
          odata_d = word_q[pick_idx_s];
          grant_d = pick_idx_s;
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (out_done || timeout_s) begin
          // done wins over a simultaneous timeout
          release_s[grant_q] = 1'b1;
          if (out_done) begin
            done_d[grant_q] = 1'b1;
          end else begin
            err_d[grant_q] = 1'b1;
          end
          rr_d    = IDXW'(rr_next(int'(grant_q), 1, CHANNELS));
          lock_d  = in_lock[grant_q];
          state_d = S_IDLE;
        end else if (cnt_q != {CNTW{1'b1}}) begin
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A slot freed this cycle may take a new word without overrun
  always_comb begin
    pend_d = pend_q;
    word_d = word_q;
    ovf_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_request[c]) begin
        if (!pend_q[c] || release_s[c]) begin
          pend_d[c] = 1'b1;
          word_d[c] = in_data[c*DATAW +: DATAW];
        end else begin
          ovf_d[c] = 1'b1;
        end
      end else if (release_s[c]) begin
        pend_d[c] = 1'b0;
      end else begin
        pend_d[c] = pend_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) word_q[c] <= '0;
      done_q  <= '0;
      err_q   <= '0;
      ovf_q   <= '0;
      oreq_q  <= 1'b0;
      odata_q <= '0;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      oreq_q  <= oreq_d;
      odata_q <= odata_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
    end
  end

  assign in_done     = done_q;
  assign in_err      = err_q;
  assign in_ovf      = ovf_q;
  assign out_request = oreq_q;
  assign out_data    = odata_q;
  assign grant       = grant_q;
  assign busy        = (state_q == S_WAIT);

endmodule

// File: tb/tb_push_arbiter.sv
// Scoreboard bench for push_arbiter: expected words are queued at push time and
// compared when the arbiter issues out_request; pulse counters track done/err/ovf.
module tb_push_arbiter;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            nRst;
  logic [CH-1:0]   in_request;
  logic [CH*DW-1:0] in_data;
  logic [CH-1:0]   in_lock;
  logic [CH-1:0]   in_done, in_err, in_ovf;
  logic            out_request;
  logic [DW-1:0]   out_data;
  logic            out_done;
  logic [1:0]      grant;
  logic            busy;

  push_arbiter #(.CHANNELS(CH), .DATAW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .nRst(nRst), .in_request(in_request), .in_data(in_data),
    .in_lock(in_lock), .in_done(in_done), .in_err(in_err), .in_ovf(in_ovf),
    .out_request(out_request), .out_data(out_data), .out_done(out_done),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0, req_cyc = 0, err_cyc = 0, dly_cnt = 0;
  int done_delay = 0, stray_req = 0, stray_ack = 0;
  int done_cnt[CH], err_cnt[CH], ovf_cnt[CH];
  int done_base[CH], err_base[CH], ovf_base[CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consumer model and output monitor, both acting on the falling edge
  initial begin
    exp_t e;
    out_done = 1'b0;
    for (int c = 0; c < CH; c++) begin done_cnt[c] = 0; err_cnt[c] = 0; ovf_cnt[c] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      out_done = 1'b0;
      if (!nRst) begin
        dly_cnt = 0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          done_cnt[c] += int'(in_done[c]);
          err_cnt[c]  += int'(in_err[c]);
          ovf_cnt[c]  += int'(in_ovf[c]);
        end
        if (in_err != '0) err_cyc = cyc;
        if (dly_cnt > 0) begin
          dly_cnt--;
          if (dly_cnt == 0) out_done = 1'b1;
        end
        if (stray_req != stray_ack) begin
          out_done  = 1'b1;
          stray_ack = stray_req;
        end
        if (out_request) begin
          req_cyc = cyc;
          if (sb.size() == 0) begin
            check_eq("unexp_req", 32'(out_request), 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("out_data", 32'(out_data), 32'(e.data));
            check_eq("grant", 32'(grant), e.ch);
          end
          if (done_delay == 0) out_done = 1'b1;
          else if (done_delay > 0) dly_cnt = done_delay;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [DW-1:0] d, input bit expect_out);
    in_request[ch] = 1'b1;
    in_data[ch*DW +: DW] = d;
    if (expect_out) sb.push_back('{ch: ch, data: d});
  endtask

  task automatic pulse();
    sync();
    in_request = '0;
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    in_request = '0;
    in_lock = '0;
    sb.delete();
    repeat (2) sync();
    nRst = 1'b1;
    sync();
  endtask

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      done_base[c] = done_cnt[c]; err_base[c] = err_cnt[c]; ovf_base[c] = ovf_cnt[c];
    end
  endtask

  task automatic chk_pulses(input string tag, input int ch, input int d, input int e, input int o);
    check_eq({tag, "_done"}, done_cnt[ch] - done_base[ch], d);
    check_eq({tag, "_err"},  err_cnt[ch]  - err_base[ch],  e);
    check_eq({tag, "_ovf"},  ovf_cnt[ch]  - ovf_base[ch],  o);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      sync();
      n++;
    end
    check_eq({tag, "_drained"}, 32'(n < 300), 32'd1);
    repeat (2) sync();
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_oreq"},  32'(out_request), 32'd0);
    check_eq({tag, "_odata"}, 32'(out_data), 32'd0);
    check_eq({tag, "_grant"}, 32'(grant), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(in_done), 32'd0);
    check_eq({tag, "_err"},   32'(in_err), 32'd0);
    check_eq({tag, "_ovf"},   32'(in_ovf), 32'd0);
    sync();
  endtask

  initial begin
    int k, n;
    nRst = 1'b0; in_request = '0; in_data = '0; in_lock = '0;
    do_reset();
    check_idle("reset");

    // single word on ch2, consumer answers two cycles after out_request
    snap();
    done_delay = 2;
    k = cyc;
    set_word(2, 16'hA5A5, 1'b1);
    pulse();
    drain("single");
    check_eq("single_latency", req_cyc - k, 3);
    for (int c = 0; c < CH; c++) chk_pulses("single", c, (c == 2) ? 1 : 0, 0, 0);

    // all channels at once from pointer 0, then wrap
    do_reset();
    snap();
    done_delay = 0;
    for (int c = 0; c < CH; c++) set_word(c, 16'(c + 1), 1'b1);
    pulse();
    drain("all4");
    set_word(0, 16'd5, 1'b1);
    set_word(3, 16'd6, 1'b1);
    pulse();
    drain("wrap");
    for (int c = 0; c < CH; c++) chk_pulses("all4", c, (c == 0 || c == 3) ? 2 : 1, 0, 0);

    // lock on ch1 keeps ch0 waiting until the lock drops
    do_reset();
    snap();
    done_delay = 1;
    in_lock = 4'b0010;
    set_word(1, 16'h0031, 1'b1);
    pulse();
    drain("lock1");
    set_word(0, 16'h00C0, 1'b0);
    set_word(1, 16'h0032, 1'b1);
    pulse();
    drain("lock2");
    repeat (5) sync();
    @(negedge clk);
    check_eq("lock_stall_busy", 32'(busy), 32'd0);
    sync();
    set_word(1, 16'h0033, 1'b1);
    pulse();
    drain("lock3");
    sb.push_back('{ch: 0, data: 16'h00C0});
    in_lock = '0;
    drain("unlock");
    chk_pulses("lock_ch1", 1, 3, 0, 0);
    chk_pulses("lock_ch0", 0, 1, 0, 0);

    // timeout with a silent consumer, then ch0 slot reusable
    snap();
    done_delay = -1;
    set_word(0, 16'h0077, 1'b1);
    pulse();
    drain("timeout");
    check_eq("timeout_delay", err_cyc - req_cyc, TO + 1);
    chk_pulses("timeout", 0, 0, 1, 0);
    snap();
    done_delay = 1;
    set_word(0, 16'h0088, 1'b1);
    pulse();
    drain("after_to");
    chk_pulses("after_to", 0, 1, 0, 0);

    // overrun on ch3 while ch0 is held in WAIT
    snap();
    done_delay = 6;
    set_word(0, 16'h0100, 1'b1);
    pulse();
    set_word(3, 16'h0011, 1'b1);
    pulse();
    set_word(3, 16'h0022, 1'b0);
    pulse();
    drain("overrun");
    chk_pulses("overrun_ch3", 3, 1, 0, 1);
    chk_pulses("overrun_ch0", 0, 1, 0, 0);

    // reset in the middle of WAIT, then a stray out_done
    done_delay = -1;
    set_word(2, 16'h0055, 1'b1);
    pulse();
    n = 0;
    while (!busy && n < 50) begin sync(); n++; end
    check_eq("rst_busy_seen", 32'(busy), 32'd1);
    sync();
    do_reset();
    snap();
    done_delay = 0;
    stray_req++;
    repeat (4) sync();
    for (int c = 0; c < CH; c++) chk_pulses("rst_mid", c, 0, 0, 0);
    check_idle("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
